// File: rtl/uart_rx_if.sv
// Host-side and line-side signals of the UART receiver, grouped for uart_rx.
// master: baud generator / line / host side; slave: the receiver itself.
interface uart_rx_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx_en;
  logic                 rx;
  logic                 rdy_clr;
  logic [DATA_BITS-1:0] data;
  logic                 rdy;
  logic                 frame_err;
  logic                 overrun;
  logic                 parity_err;
  logic [2:0]           state_dbg;

  // Handshake: rdy stays high from word completion until the host pulses
  // rdy_clr; a completion coinciding with rdy_clr wins and is not an overrun.
  modport master (
    output rx_en, rx, rdy_clr,
    input  data, rdy, frame_err, overrun, parity_err, state_dbg
  );

  modport slave (
    input  rx_en, rx, rdy_clr,
    output data, rdy, frame_err, overrun, parity_err, state_dbg
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver on a 16x oversample tick: start validation, LSB-first data,
// stop check, rdy/clear handshake. Optional even parity via UART_RX_PARITY_EN.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.slave  bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t               state, state_nxt;
  logic [TW-1:0]        tick_cnt, tick_nxt;
  logic [BW-1:0]        bit_cnt, bit_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_q, data_nxt;
  logic                 rdy_q, rdy_nxt;
  logic                 ferr_q, ferr_nxt;
  logic                 ovr_q, ovr_nxt;
  logic                 perr_q, perr_nxt;
  logic                 sync1, rx_s;
`ifdef UART_RX_PARITY_EN
  logic                 par_bit, par_nxt;
`endif

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      sync1 <= bus.rx;
      rx_s  <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      data_q   <= '0;
      rdy_q    <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      perr_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_nxt;
      bit_cnt  <= bit_nxt;
      shift    <= shift_nxt;
      data_q   <= data_nxt;
      rdy_q    <= rdy_nxt;
      ferr_q   <= ferr_nxt;
      ovr_q    <= ovr_nxt;
      perr_q   <= perr_nxt;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) par_bit <= 1'b0;
    else     par_bit <= par_nxt;
  end
`endif

  always_comb begin
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift;
    data_nxt  = data_q;
    rdy_nxt   = bus.rdy_clr ? 1'b0 : rdy_q;
    ovr_nxt   = bus.rdy_clr ? 1'b0 : ovr_q;
    ferr_nxt  = ferr_q;
    perr_nxt  = perr_q;
`ifdef UART_RX_PARITY_EN
    par_nxt   = par_bit;
`endif
    if (bus.rx_en) begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state_nxt = START;
            tick_nxt  = '0;
          end
        end
        START: begin
          if (tick_cnt == TICK_MID) begin
            tick_nxt  = '0;
            bit_nxt   = '0;
            state_nxt = rx_s ? IDLE : DATA;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (tick_cnt == TICK_LAST) begin
            shift_nxt = {rx_s, shift[DATA_BITS-1:1]};
            tick_nxt  = '0;
            bit_nxt   = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_nxt = PARITY;
`else
              state_nxt = STOP;
`endif
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (tick_cnt == TICK_LAST) begin
            par_nxt   = rx_s;
            tick_nxt  = '0;
            state_nxt = STOP;
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          // Leave at mid-stop-bit so a back-to-back start edge is not missed.
          if (tick_cnt == TICK_LAST) begin
            tick_nxt  = '0;
            state_nxt = IDLE;
            if (rx_s) begin
              data_nxt = shift;
              rdy_nxt  = 1'b1;
              ferr_nxt = 1'b0;
              if (rdy_q && !bus.rdy_clr) ovr_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
              perr_nxt = (^shift) ^ par_bit;
`endif
            end else begin
              ferr_nxt = 1'b1;
            end
          end else begin
            tick_nxt = tick_cnt + 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign bus.data       = data_q;
  assign bus.rdy        = rdy_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = ovr_q;
  assign bus.parity_err = perr_q;
  assign bus.state_dbg  = state;
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: rx_en every clk, frames driven bit by bit,
// expected words queued at send time and compared when the receiver delivers.
module tb_uart_rx;
  localparam int DB  = 8;
  localparam int OS  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   start_cyc = 0;
  int   rise_cyc = 0;
  logic rdy_d = 1'b0;
  logic [DB-1:0] exp_q[$];
  logic [DB-1:0] exp_w;

  uart_rx_if #(.DATA_BITS(DB)) bus ();

  uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // rdy rising-edge timestamp for the latency check
  always @(negedge clk) begin
    if (bus.rdy && !rdy_d) rise_cyc = cyc;
    rdy_d = bus.rdy;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (OS) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input logic bad_par);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < DB; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ bad_par);
`endif
    drive_bit(stop_bit);
    bus.rx = 1'b1;
  endtask

  task automatic wait_rdy();
    int i;
    for (i = 0; i < 64; i++) begin
      @(negedge clk);
      if (bus.rdy) break;
    end
    if (i == 64) check("rdy_timeout", {31'd0, bus.rdy}, 32'd1);
  endtask

  task automatic pulse_clr();
    @(posedge clk);
    #1 bus.rdy_clr = 1'b1;
    @(posedge clk);
    #1 bus.rdy_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.rx_en   = 1'b1;
    bus.rx      = 1'b1;
    bus.rdy_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_data", bus.data, 0);
    check("rst_rdy", bus.rdy, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_ovr", bus.overrun, 0);
    check("rst_perr", bus.parity_err, 0);
    check("rst_state", bus.state_dbg, 0);
    rst = 1'b0;
    idle(4);

    // 0xA5 with latency window 2+16*9.5 clk +/-2
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_rdy();
    exp_w = exp_q.pop_front();
    check("a5_data", bus.data, exp_w);
    check("a5_ferr", bus.frame_err, 0);
    check("a5_lat_ok", ((rise_cyc - start_cyc) >= 152 && (rise_cyc - start_cyc) <= 156), 1);
    pulse_clr();
    check("a5_clr_rdy", bus.rdy, 0);

    // glitch: 4 ticks low is rejected at mid-start
    @(posedge clk);
    #1 bus.rx = 1'b0;
    idle(4);
    bus.rx = 1'b1;
    idle(30);
    @(negedge clk);
    check("glitch_state", bus.state_dbg, 0);
    check("glitch_rdy", bus.rdy, 0);
    check("glitch_ferr", bus.frame_err, 0);
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    wait_rdy();
    exp_w = exp_q.pop_front();
    check("3c_data", bus.data, exp_w);
    pulse_clr();

    // bad stop bit: frame error, data/rdy untouched
    send_frame(8'h81, 1'b0, 1'b0);
    idle(32);
    @(negedge clk);
    check("ferr_set", bus.frame_err, 1);
    check("ferr_rdy", bus.rdy, 0);
    check("ferr_data_kept", bus.data, 8'h3C);
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0);
    wait_rdy();
    exp_w = exp_q.pop_front();
    check("7e_data", bus.data, exp_w);
    check("7e_ferr_clr", bus.frame_err, 0);
    pulse_clr();

    // back-to-back without clear: overrun, first word lost
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h0F);
    send_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h0F, 1'b1, 1'b0);
    idle(4);
    @(negedge clk);
    void'(exp_q.pop_front());
    exp_w = exp_q.pop_front();
    check("ovr_data", bus.data, exp_w);
    check("ovr_rdy", bus.rdy, 1);
    check("ovr_flag", bus.overrun, 1);
    pulse_clr();
    check("ovr_clr_rdy", bus.rdy, 0);
    check("ovr_clr_flag", bus.overrun, 0);

    // reset in the middle of data bit 4 of 0xFF
    @(posedge clk);
    #1;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    idle(OS / 2);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mrst_data", bus.data, 0);
    check("mrst_rdy", bus.rdy, 0);
    check("mrst_ferr", bus.frame_err, 0);
    check("mrst_ovr", bus.overrun, 0);
    check("mrst_state", bus.state_dbg, 0);
    #1 rst = 1'b0;
    idle(32);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1, 1'b0);
    wait_rdy();
    exp_w = exp_q.pop_front();
    check("12_data", bus.data, exp_w);
    pulse_clr();

`ifdef UART_RX_PARITY_EN
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b1);
    wait_rdy();
    exp_w = exp_q.pop_front();
    check("par_bad_data", bus.data, exp_w);
    check("par_bad_err", bus.parity_err, 1);
    pulse_clr();
    exp_q.push_back(8'h03);
    send_frame(8'h03, 1'b1, 1'b0);
    wait_rdy();
    exp_w = exp_q.pop_front();
    check("par_ok_rdy", bus.rdy, 1);
    check("par_ok_err", bus.parity_err, 0);
    pulse_clr();
`else
    check("perr_tied", bus.parity_err, 0);
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
